hex_display_ctrl: RTL and testbench

//  Registered, parametrised driver for NUM_DIGITS active-low 7-segment displays (DE2-115 HEX0..HEX7).

---
 rtl/hex_display_pkg.sv | 36 +++
 rtl/hex_seg_decoder.sv | 20 ++
 rtl/hex_display_ctrl.sv | 103 ++++++++++
 tb/tb_hex_display_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_pkg
//  Description : Shared constants for the hex 7-segment display driver.
//                SEG_BLANK is the all-segments-off pattern. SEG_LUT maps a
//                nibble to its gfedcba pattern (bit6 = g ... bit0 = a).
//                Segments are active-low, so a 0 bit lights the segment.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry 15 is written first because this is a packed array.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage : hex_display_pkg
`default_nettype wire

// File: rtl/hex_seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : hex_seg_decoder
//  Description : Combinational decoder from a nibble to an active-low
//                7-segment pattern (gfedcba).
//  Ports       : digit  in  4  hex digit to decode
//                seg    out 7  segment pattern, active-low, bit6 = g
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[digit];

endmodule : hex_seg_decoder
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_ctrl
//  Description : Registered driver for NUM_DIGITS active-low 7-segment
//                displays. It captures a hex value on a load strobe and
//                supports optional leading-zero blanking, per-digit
//                blinking and a global display enable.
//  Ports       : clk          in   1             system clock, rising edge
//                rst          in   1             synchronous reset, active-high
//                load         in   1             capture value/blank_lz/blink_mask
//                value        in   4*NUM_DIGITS  nibble i drives digit i
//                blank_lz     in   1             leading-zero blanking enable
//                blink_mask   in   NUM_DIGITS    bit i makes digit i blink
//                enable       in   1             1 = display on, 0 = all off
//                seg_out      out  7*NUM_DIGITS  active-low segments per digit
//                blink_phase  out  1             1 = blinking digits visible
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    enable,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    blink_phase
);

  localparam int              CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  // Captured display state
  logic [4*NUM_DIGITS-1:0] value_q;
  logic                    lz_q;
  logic [NUM_DIGITS-1:0]   mask_q;

  // Free-running blink timebase
  logic [CNT_W-1:0]        blink_cnt;
  logic                    cnt_wrap;
  logic                    phase_next;

  // lz_run[i] = 1 when nibbles NUM_DIGITS-1 down to i are all zero.
  // Digit 0 is never blanked by this rule, so the chain stops at index 1.
  logic [NUM_DIGITS:1]     lz_run;
  logic [7*NUM_DIGITS-1:0] seg_next;

  assign cnt_wrap   = (blink_cnt == CNT_MAX);
  // The output register uses the phase that becomes visible on the same
  // edge, which keeps blinking digits in step with blink_phase.
  assign phase_next = blink_phase ^ cnt_wrap;

  assign lz_run[NUM_DIGITS] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [6:0] dec_seg;
    logic       lz_blank;
    logic       blink_blank;

    hex_seg_decoder u_dec (
      .digit (value_q[4*i +: 4]),
      .seg   (dec_seg)
    );

    if (i == 0) begin : g_lsd
      assign lz_blank = 1'b0;
    end else begin : g_upper
      assign lz_run[i] = lz_run[i+1] & (value_q[4*i +: 4] == 4'h0);
      assign lz_blank  = lz_q & lz_run[i];
    end

    assign blink_blank        = mask_q[i] & ~phase_next;
    assign seg_next[7*i +: 7] = (lz_blank | blink_blank | ~enable) ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q     <= '0;
      lz_q        <= 1'b0;
      mask_q      <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      seg_out     <= '1;
    end else begin
      if (load) begin
        value_q <= value;
        lz_q    <= blank_lz;
        mask_q  <= blink_mask;
      end
      blink_cnt   <= cnt_wrap ? '0 : blink_cnt + CNT_W'(1);
      blink_phase <= phase_next;
      seg_out     <= seg_next;
    end
  end

endmodule : hex_display_ctrl
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_display_ctrl
//  Description : Directed self-checking bench for hex_display_ctrl with
//                NUM_DIGITS = 4 and BLINK_DIV = 4.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int BLINK_DIV  = 4;

  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_5 = 7'b0010010;
  localparam logic [6:0] S_8 = 7'b0000000;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_F = 7'b0001110;
  localparam logic [6:0] S_X = 7'b1111111;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    enable;
  logic [7*NUM_DIGITS-1:0] seg_out;
  logic                    blink_phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference blink timebase: phase holds for BLINK_DIV edges, restarts on rst.
  int   m_cnt   = 0;
  logic m_phase = 1'b1;

  hex_display_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .blank_lz    (blank_lz),
    .blink_mask  (blink_mask),
    .enable      (enable),
    .seg_out     (seg_out),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt   <= 0;
      m_phase <= 1'b1;
    end else if (m_cnt == BLINK_DIV - 1) begin
      m_cnt   <= 0;
      m_phase <= ~m_phase;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; returns on the following falling edge, away from the edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic lz, input logic [3:0] m);
    value      = v;
    blank_lz   = lz;
    blink_mask = m;
    load       = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    logic [27:0] exp_seg;
    int          guard;

    // 1. Reset held with a pending load
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; blank_lz = 1'b0;
    blink_mask = '0; enable = 1'b1;
    repeat (3) step();
    check_val("reset_seg", 32'(seg_out), 32'h0FFFFFFF);
    check_val("reset_phase", 32'(blink_phase), 32'h1);
    rst = 1'b0; load = 1'b0;
    step();
    check_val("post_reset_zero", 32'(seg_out), 32'({S_0, S_0, S_0, S_0}));

    // 2. Plain decode, two-edge latency
    do_load(16'h12AF, 1'b0, 4'b0000);
    check_val("load_latency_old", 32'(seg_out), 32'({S_0, S_0, S_0, S_0}));
    step();
    check_val("decode_12AF", 32'(seg_out), 32'({S_1, S_2, S_A, S_F}));

    // 3. Leading-zero blanking
    do_load(16'h0050, 1'b1, 4'b0000);
    step();
    check_val("lz_0050", 32'(seg_out), 32'({S_X, S_X, S_5, S_0}));
    do_load(16'h0000, 1'b1, 4'b0000);
    step();
    check_val("lz_0000", 32'(seg_out), 32'({S_X, S_X, S_X, S_0}));

    // 4. Blinking digit 0
    do_load(16'h8888, 1'b0, 4'b0001);
    step();
    for (int c = 0; c < 12; c++) begin
      exp_seg = {S_8, S_8, S_8, (m_phase ? S_8 : S_X)};
      check_val($sformatf("blink_seg_%0d", c), 32'(seg_out), 32'(exp_seg));
      check_val($sformatf("blink_phase_%0d", c), 32'(blink_phase), 32'(m_phase));
      step();
    end

    // 5. Display enable
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_val($sformatf("disabled_%0d", c), 32'(seg_out), 32'h0FFFFFFF);
      check_val($sformatf("disabled_phase_%0d", c), 32'(blink_phase), 32'(m_phase));
    end
    enable = 1'b1;
    step();
    exp_seg = {S_8, S_8, S_8, (m_phase ? S_8 : S_X)};
    check_val("reenable_seg", 32'(seg_out), 32'(exp_seg));
    check_val("reenable_phase", 32'(blink_phase), 32'(m_phase));

    // 6. Reset while phase = 0, with a competing load
    guard = 0;
    while (m_phase !== 1'b0 && guard < 20) begin
      step();
      guard++;
    end
    check_val("reach_phase0", 32'(blink_phase), 32'h0);
    rst = 1'b1; load = 1'b1; value = 16'h1234; blink_mask = 4'b1111;
    step();
    check_val("midblink_rst_seg", 32'(seg_out), 32'h0FFFFFFF);
    check_val("midblink_rst_phase", 32'(blink_phase), 32'h1);
    rst = 1'b0; load = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check_val($sformatf("after_rst_seg_%0d", c), 32'(seg_out), 32'({S_0, S_0, S_0, S_0}));
      check_val($sformatf("after_rst_phase_%0d", c), 32'(blink_phase), 32'(c < 3 ? 1 : 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hex_display_ctrl
`default_nettype wire
